riscv_debug_scan: RTL and testbench

Board-level debug sequencer for the pipelined RISC-V datapath. On a step request it issues a one-cycle CPU clock-enable, then sweeps the datapath's `ssdSel` (0–11) and `ledSel` (0–2) debug selects and captures each observed value into a 15-entry snapshot buffer. Software or the display driver then reads the snapshot through a random-access port. It sits between the debounced board buttons and the datapath's debug mux inputs, and replaces hand-sequenced select sweeping.

---
 rtl/riscv_debug_scan.sv | 152 +++++++++++++++
 tb/tb_riscv_debug_scan.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_debug_scan.sv
// Debug sequencer: issues a one-cycle CPU step, sweeps ssdSel/ledSel and captures 15 words.
// Optional feature macro: DBG_SCAN_CHECKSUM_EN (modular sum of the snapshot readable at rd_addr 15).
module riscv_debug_scan #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_req,
  input  logic        run_mode,
  input  logic [12:0] ssd_in,
  input  logic [15:0] leds_in,
  input  logic [3:0]  rd_addr,
  output logic        cpu_step,
  output logic [3:0]  ssdSel,
  output logic [1:0]  ledSel,
  output logic        busy,
  output logic        snap_valid,
  output logic [15:0] rd_data
);

  localparam logic [3:0] LP_SETTLE    = 4'(SETTLE);
  localparam logic [3:0] LP_LAST_WORD = 4'd14;
  localparam logic [3:0] LP_NUM_SSD   = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_SCAN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_k;
  logic [3:0]  r_cnt;
  logic        r_cpu_step;
  logic        r_busy;
  logic        r_snap_valid;
  logic [3:0]  r_ssd_sel;
  logic [1:0]  r_led_sel;
  logic [15:0] r_snap [15];
`ifdef DBG_SCAN_CHECKSUM_EN
  logic [15:0] r_cksum;
`endif

  logic        w_last_hold;
  logic [3:0]  w_k_nxt;
  logic [15:0] w_word;
  logic [3:0]  w_ssd_sel_nxt;
  logic [1:0]  w_led_sel_nxt;

  assign w_last_hold = (r_cnt == LP_SETTLE);
  assign w_k_nxt     = r_k + 4'd1;
  assign w_word      = (r_k < LP_NUM_SSD) ? {3'b000, ssd_in} : leds_in;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_ssd_sel_nxt = '0;
    w_led_sel_nxt = '0;
    if (w_k_nxt < LP_NUM_SSD) w_ssd_sel_nxt = w_k_nxt;
    else                      w_led_sel_nxt = 2'(w_k_nxt - LP_NUM_SSD);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_cnt        <= '0;
      r_cpu_step   <= 1'b0;
      r_busy       <= 1'b0;
      r_snap_valid <= 1'b0;
      r_ssd_sel    <= '0;
      r_led_sel    <= '0;
      // NOTE: the snapshot is flop-based and cleared on reset so reads after reset return zero.
      for (int i = 0; i < 15; i++) r_snap[i] <= '0;
`ifdef DBG_SCAN_CHECKSUM_EN
      r_cksum      <= '0;
`endif
    end else begin
      r_cpu_step   <= 1'b0;
      r_snap_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ssd_sel <= '0;
          r_led_sel <= '0;
          if (step_req || run_mode) begin
            r_state    <= S_STEP;
            r_cpu_step <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_STEP: begin
          r_k       <= '0;
          r_cnt     <= '0;
          r_ssd_sel <= '0;
          r_led_sel <= '0;
          r_state   <= S_SCAN;
`ifdef DBG_SCAN_CHECKSUM_EN
          r_cksum   <= '0;
`endif
        end
        S_SCAN: begin
          if (w_last_hold) begin
            r_snap[r_k] <= w_word;
`ifdef DBG_SCAN_CHECKSUM_EN
            r_cksum     <= r_cksum + w_word;
`endif
            r_cnt       <= '0;
            if (r_k == LP_LAST_WORD) begin
              r_state      <= S_DONE;
              r_snap_valid <= 1'b1;
            end else begin
              // The next select is launched on the capture edge, opening its hold window.
              r_k       <= w_k_nxt;
              r_ssd_sel <= w_ssd_sel_nxt;
              r_led_sel <= w_led_sel_nxt;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_ssd_sel <= '0;
          r_led_sel <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr != 4'd15) begin
      rd_data = r_snap[rd_addr];
    end else begin
`ifdef DBG_SCAN_CHECKSUM_EN
      rd_data = r_cksum;
`else
      rd_data = 16'h0000;
`endif
    end
  end

  assign cpu_step   = r_cpu_step;
  assign busy       = r_busy;
  assign snap_valid = r_snap_valid;
  assign ssdSel     = r_ssd_sel;
  assign ledSel     = r_led_sel;

endmodule

// File: tb/tb_riscv_debug_scan.sv
// Bench for riscv_debug_scan: a randomized datapath model feeds ssd_in/leds_in from selects,
// and scan timing, select sweep and snapshot contents are checked against expected values.
module tb_riscv_debug_scan;

  parameter int SETTLE = 2;
  localparam int HOLD   = SETTLE + 1;
  localparam int LAT    = 2 + 15 * HOLD;   // negedge index of snap_valid, counting the cpu_step cycle as 1
  localparam int PERIOD = LAT + 1;         // STEP + SCAN + DONE + one IDLE cycle

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_req = 1'b0;
  logic        run_mode = 1'b0;
  logic [12:0] ssd_in = '0;
  logic [15:0] leds_in = '0;
  logic [3:0]  rd_addr = '0;
  logic        cpu_step;
  logic [3:0]  ssdSel;
  logic [1:0]  ledSel;
  logic        busy;
  logic        snap_valid;
  logic [15:0] rd_data;

  int n_pass  = 0;
  int n_total = 0;

  logic [12:0] ssd_tbl [12];
  logic [15:0] led_tbl [3];

  riscv_debug_scan #(.SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .step_req  (step_req),
    .run_mode  (run_mode),
    .ssd_in    (ssd_in),
    .leds_in   (leds_in),
    .rd_addr   (rd_addr),
    .cpu_step  (cpu_step),
    .ssdSel    (ssdSel),
    .ledSel    (ledSel),
    .busy      (busy),
    .snap_valid(snap_valid),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // Datapath model: outputs are garbage until the select pair has been stable for SETTLE cycles.
  logic [5:0] prev_sel = '0;
  int         sel_age  = 100;
  always @(negedge clk) begin
    if ({ssdSel, ledSel} != prev_sel) begin
      prev_sel = {ssdSel, ledSel};
      sel_age  = 0;
    end else if (sel_age < 100) begin
      sel_age++;
    end
    if (sel_age >= SETTLE) begin
      ssd_in  = (ssdSel < 4'd12) ? ssd_tbl[ssdSel] : 13'h1FFF;
      leds_in = (ledSel < 2'd3) ? led_tbl[ledSel] : 16'hFFFF;
    end else begin
      ssd_in  = 13'($urandom);
      leds_in = 16'($urandom);
    end
  end

  function automatic logic [15:0] exp_word(input int k);
    if (k < 12) return {3'b000, ssd_tbl[k]};
    return led_tbl[k - 12];
  endfunction

  function automatic logic [15:0] exp_cksum();
    int sum = 0;
    for (int k = 0; k < 15; k++) sum += int'(exp_word(k));
`ifdef DBG_SCAN_CHECKSUM_EN
    return 16'(sum);
`else
    return (sum == -1) ? 16'h1 : 16'h0000;
`endif
  endfunction

  task automatic randomize_tables();
    for (int i = 0; i < 12; i++) ssd_tbl[i] = 13'($urandom);
    for (int i = 0; i < 3; i++)  led_tbl[i] = 16'($urandom);
  endtask

  task automatic check_reads(input string tag, input bit cleared);
    logic [15:0] exp;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      if (cleared)     exp = 16'h0000;
      else if (a < 15) exp = exp_word(a);
      else             exp = exp_cksum();
      n_total++;
      if (rd_data !== exp)
        $display("FAIL %s rd_addr=%0d got=%h expected=%h", tag, a, rd_data, exp);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({cpu_step, busy, snap_valid, ssdSel, ledSel} !== 9'b0)
      $display("FAIL reset_outputs got=%b expected=0", {cpu_step, busy, snap_valid, ssdSel, ledSel});
    else n_pass++;
    rst = 1'b0;
    check_reads("reset_reads", 1'b1);
  endtask

  // One step-and-scan; optional extra step_req pulse at negedge index reject_at.
  task automatic test_single_step(input string tag, input int reject_at);
    int n_step = 0;
    int n_valid = 0;
    int exp_k;
    logic [3:0] exp_ssd;
    logic [1:0] exp_led;
    randomize_tables();
    @(negedge clk);
    step_req = 1'b1;
    for (int i = 1; i <= LAT + 3; i++) begin
      @(negedge clk);
      step_req = (i == reject_at);
      if (cpu_step) n_step++;
      if (snap_valid) n_valid++;
      n_total++;
      if (cpu_step !== (i == 1)) $display("FAIL %s cpu_step i=%0d got=%b expected=%b", tag, i, cpu_step, i == 1);
      else n_pass++;
      n_total++;
      if (snap_valid !== (i == LAT)) $display("FAIL %s snap_valid i=%0d got=%b expected=%b", tag, i, snap_valid, i == LAT);
      else n_pass++;
      n_total++;
      if (busy !== (i <= LAT)) $display("FAIL %s busy i=%0d got=%b expected=%b", tag, i, busy, i <= LAT);
      else n_pass++;
      if (i != LAT) begin
        exp_ssd = '0;
        exp_led = '0;
        if (i >= 2 && i < LAT) begin
          exp_k = (i - 2) / HOLD;
          if (exp_k < 12) exp_ssd = 4'(exp_k);
          else            exp_led = 2'(exp_k - 12);
        end
        n_total++;
        if (ssdSel !== exp_ssd || ledSel !== exp_led)
          $display("FAIL %s selects i=%0d got=%0d/%0d expected=%0d/%0d", tag, i, ssdSel, ledSel, exp_ssd, exp_led);
        else n_pass++;
      end
    end
    n_total++;
    if (n_step != 1 || n_valid != 1)
      $display("FAIL %s pulse_counts got=%0d/%0d expected=1/1", tag, n_step, n_valid);
    else n_pass++;
    check_reads(tag, 1'b0);
  endtask

  task automatic test_run_mode();
    int last_step = -1;
    int n_step = 0;
    int n_valid = 0;
    int drain = 0;
    randomize_tables();
    @(negedge clk);
    run_mode = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (cpu_step) begin
        if (last_step >= 0) begin
          n_total++;
          if (t - last_step != PERIOD)
            $display("FAIL run_step_interval got=%0d expected=%0d", t - last_step, PERIOD);
          else n_pass++;
        end
        last_step = t;
        n_step++;
      end
      if (snap_valid) begin
        n_total++;
        if (last_step < 0 || t - last_step != LAT - 1)
          $display("FAIL run_valid_offset got=%0d expected=%0d", t - last_step, LAT - 1);
        else n_pass++;
        n_valid++;
      end
    end
    run_mode = 1'b0;
    n_total++;
    if (n_step != 199 / PERIOD + 1)
      $display("FAIL run_step_count got=%0d expected=%0d", n_step, 199 / PERIOD + 1);
    else n_pass++;
    n_total++;
    if (n_valid != (200 - LAT) / PERIOD + 1)
      $display("FAIL run_valid_count got=%0d expected=%0d", n_valid, (200 - LAT) / PERIOD + 1);
    else n_pass++;
    while (busy === 1'b1 && drain < 2 * PERIOD) begin
      @(negedge clk);
      drain++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL run_drain busy got=%b expected=0", busy);
    else n_pass++;
    check_reads("run_mode_reads", 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    int n_valid = 0;
    randomize_tables();
    @(negedge clk);
    step_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      step_req = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (busy !== 1'b0 || ssdSel !== 4'd0 || ledSel !== 2'd0 || cpu_step !== 1'b0)
      $display("FAIL mid_reset_state got busy=%b ssdSel=%0d ledSel=%0d expected 0/0/0", busy, ssdSel, ledSel);
    else n_pass++;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (snap_valid) n_valid++;
    end
    n_total++;
    if (n_valid != 0 || busy !== 1'b0)
      $display("FAIL mid_reset_quiet got valid=%0d busy=%b expected 0/0", n_valid, busy);
    else n_pass++;
    check_reads("mid_reset_reads", 1'b1);
  endtask

  initial begin
    randomize_tables();
    test_reset();
    test_single_step("single_step", -1);
    test_single_step("busy_reject", 10);
    test_run_mode();
    test_reset_mid_scan();
    test_single_step("after_reset", -1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
